i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_rr_pick.sv | 33 +++
 rtl/i2c_arbiter.sv | 158 +++++++++++++++
 tb/tb_i2c_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT_DONE,
        RESP
    } state_t;

    localparam int         I2C_WORD_W = 24;
    localparam logic [7:0] CODEC_ADDR = 8'h34;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap-around.
module i2c_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Scan from the farthest offset down so the closest one to ptr is the last to win.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(ptr, i)]) begin
                valid = 1'b1;
                index = wrap_idx(ptr, i);
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C controller among NUM_REQ requesters with round-robin grants,
// NACK/timeout retries and a one-cycle completion pulse per transfer.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][I2C_WORD_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic                                rsp_ack,
    output logic                                busy,
    output logic                                i2c_start,
    output logic [I2C_WORD_W-1:0]               i2c_data,
    input  logic                                i2c_done,
    input  logic                                i2c_ack
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REQ - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        winner_q, winner_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [TO_W-1:0]         timeout_q, timeout_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                    rsp_ack_q, rsp_ack_d;
    logic                    busy_q, busy_d;
    logic                    i2c_start_q, i2c_start_d;
    logic [I2C_WORD_W-1:0]   i2c_data_q, i2c_data_d;

    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_index;
    logic                    attempt_failed;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_index)
    );

    // A NACK and a timeout are handled identically: retry until the budget is spent.
    assign attempt_failed = (i2c_done && !i2c_ack) || (!i2c_done && (timeout_q == TO_LAST));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        retry_d     = retry_q;
        timeout_d   = timeout_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_ack_d   = 1'b0;
        busy_d      = busy_q;
        i2c_start_d = 1'b0;
        i2c_data_d  = i2c_data_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    winner_d   = pick_index;
                    i2c_data_d = req_data[pick_index];
                    gnt_d      = NUM_REQ'(1) << pick_index;
                    retry_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                i2c_start_d = 1'b1;
                timeout_d   = '0;
                state_d     = SETTLE;
            end
            // The controller still shows done from its previous transfer here.
            SETTLE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i2c_done && i2c_ack) begin
                    rsp_valid_d = gnt_q;
                    rsp_ack_d   = 1'b1;
                    state_d     = RESP;
                end else if (attempt_failed) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ISSUE;
                    end else begin
                        rsp_valid_d = gnt_q;
                        state_d     = RESP;
                    end
                end else if (timeout_q != TO_LAST) begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            RESP: begin
                gnt_d   = '0;
                ptr_d   = (winner_q == IDX_LAST) ? '0 : winner_q + 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            retry_q     <= '0;
            timeout_q   <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            i2c_start_q <= 1'b0;
            i2c_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            retry_q     <= retry_d;
            timeout_q   <= timeout_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ack_q   <= rsp_ack_d;
            busy_q      <= busy_d;
            i2c_start_q <= i2c_start_d;
            i2c_data_q  <= i2c_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ack   = rsp_ack_q;
    assign busy      = busy_q;
    assign i2c_start = i2c_start_q;
    assign i2c_data  = i2c_data_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a small behavioural I2C controller model.
module tb_i2c_arbiter;
    import i2c_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset = 1'b1;
    logic [2:0]                      req = '0;
    logic [2:0][I2C_WORD_W-1:0]      req_data = '0;
    logic [2:0]                      gnt;
    logic [2:0]                      rsp_valid;
    logic                            rsp_ack;
    logic                            busy;
    logic                            i2c_start;
    logic [I2C_WORD_W-1:0]           i2c_data;
    logic                            i2c_done = 1'b1;
    logic                            i2c_ack = 1'b1;

    int errors = 0;
    int checks = 0;
    int overlap_cnt = 0;

    int   model_lat = 20;
    bit   model_ack = 1'b1;
    bit   model_hang = 1'b0;
    int   model_cnt = 0;
    bit   start_seen = 1'b0;
    int   start_count = 0;
    logic [I2C_WORD_W-1:0] start_data [0:15];

    always #5 clk = ~clk;

    i2c_arbiter #(
        .NUM_REQ        (3),
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (8192)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ack   (rsp_ack),
        .busy      (busy),
        .i2c_start (i2c_start),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack)
    );

    // Controller model: drops done the cycle after it sees start, raises it model_lat cycles later.
    always @(posedge clk) begin
        #2;
        if (start_seen) begin
            i2c_done  = 1'b0;
            model_cnt = model_lat;
        end else begin
            if (model_cnt > 0) model_cnt--;
            if (!i2c_done && model_cnt == 0 && !model_hang) begin
                i2c_done = 1'b1;
                i2c_ack  = model_ack;
            end
        end
        start_seen = i2c_start;
        if (i2c_start) begin
            start_data[start_count % 16] = i2c_data;
            start_count++;
        end
    end

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if ($countones(gnt) > 1 || $countones(rsp_valid) > 1) overlap_cnt++;
            if (rsp_valid != '0) break;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({gnt, rsp_valid, rsp_ack, busy, i2c_start, i2c_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got gnt=%b rsp=%b ack=%b busy=%b start=%b data=%h, expected all zero",
                     gnt, rsp_valid, rsp_ack, busy, i2c_start, i2c_data);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        int n;
        model_lat = 20;
        model_ack = 1'b1;
        @(negedge clk);
        req_data[0] = {CODEC_ADDR, 16'h0000};
        req_data[1] = {CODEC_ADDR, 16'h1001};
        req_data[2] = {CODEC_ADDR, 16'h2002};
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(200, n);
            checks++;
            if (rsp_valid !== exp_order[k]) begin
                errors++;
                $display("[TB] FAIL rr_order%0d: got rsp_valid=%b expected %b", k, rsp_valid, exp_order[k]);
            end
            checks++;
            if (rsp_ack !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_ack%0d: got %b expected 1", k, rsp_ack);
            end
        end
        req = '0;
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL rr_onehot: got %0d multi-hot cycles expected 0", overlap_cnt);
        end
    endtask

    task automatic test_single();
        int n;
        int stale_bad = 0;
        model_lat = 3840;
        model_ack = 1'b1;
        @(negedge clk);
        req_data[0] = {CODEC_ADDR, 16'h0C10};
        req = 3'b001;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || i2c_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_grant: got gnt=%b start=%b busy=%b expected 001/0/1", gnt, i2c_start, busy);
        end
        @(negedge clk);
        checks++;
        if (i2c_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_start_latency: got start=%b expected 1", i2c_start);
        end
        checks++;
        if (i2c_data !== 24'h340C10) begin
            errors++;
            $display("[TB] FAIL single_data: got %h expected 340c10", i2c_data);
        end
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid !== 3'b000 || i2c_start !== 1'b0) stale_bad++;
        end
        checks++;
        if (stale_bad !== 0) begin
            errors++;
            $display("[TB] FAIL stale_done: got %0d early rsp/start cycles expected 0", stale_bad);
        end
        wait_rsp(5000, n);
        checks++;
        if (rsp_valid !== 3'b001 || rsp_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_rsp: got rsp=%b ack=%b expected 001/1", rsp_valid, rsp_ack);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || rsp_valid !== 3'b000) begin
            errors++;
            $display("[TB] FAIL single_idle: got gnt=%b busy=%b rsp=%b expected 000/0/000", gnt, busy, rsp_valid);
        end
    endtask

    task automatic test_ptr_order();
        int n;
        model_lat = 20;
        req_data[0] = {CODEC_ADDR, 16'h0A0A};
        req_data[1] = {CODEC_ADDR, 16'h0B0B};
        req = 3'b011;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("[TB] FAIL ptr_priority: got gnt=%b expected 010", gnt);
        end
        wait_rsp(200, n);
        checks++;
        if (rsp_valid !== 3'b010) begin
            errors++;
            $display("[TB] FAIL ptr_rsp: got %b expected 010", rsp_valid);
        end
        req = '0;
    endtask

    task automatic test_nack_retry();
        int n;
        int s0;
        int bad = 0;
        model_lat = 10;
        model_ack = 1'b0;
        @(negedge clk);
        s0 = start_count;
        req_data[2] = {CODEC_ADDR, 16'h1234};
        req = 3'b100;
        @(negedge clk);
        req_data[2] = 24'hFFFFFF;
        wait_rsp(500, n);
        checks++;
        if (rsp_valid !== 3'b100 || rsp_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nack_rsp: got rsp=%b ack=%b expected 100/0", rsp_valid, rsp_ack);
        end
        req = '0;
        checks++;
        if (start_count - s0 !== 4) begin
            errors++;
            $display("[TB] FAIL nack_starts: got %0d expected 4", start_count - s0);
        end
        for (int k = s0; k < start_count; k++) begin
            if (start_data[k % 16] !== 24'h341234) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL nack_data_latched: got %0d differing words expected 0", bad);
        end
        model_ack = 1'b1;
    endtask

    task automatic test_timeout();
        int n;
        int s0;
        model_hang = 1'b1;
        @(negedge clk);
        s0 = start_count;
        req_data[1] = {CODEC_ADDR, 16'h5555};
        req = 3'b010;
        wait_rsp(40000, n);
        checks++;
        if (rsp_valid !== 3'b010 || rsp_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_rsp: got rsp=%b ack=%b expected 010/0", rsp_valid, rsp_ack);
        end
        checks++;
        if (n !== 32777) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: got %0d expected 32777", n);
        end
        checks++;
        if (start_count - s0 !== 4) begin
            errors++;
            $display("[TB] FAIL timeout_starts: got %0d expected 4", start_count - s0);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int rv = 0;
        model_lat = 20;
        @(negedge clk);
        req_data[2] = {CODEC_ADDR, 16'h5A5A};
        req = 3'b100;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gnt !== 3'b100) begin
            errors++;
            $display("[TB] FAIL mid_precondition: got busy=%b gnt=%b expected 1/100", busy, gnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_ack, busy, i2c_start, i2c_data} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: got gnt=%b rsp=%b ack=%b busy=%b start=%b data=%h expected all zero",
                     gnt, rsp_valid, rsp_ack, busy, i2c_start, i2c_data);
        end
        req = '0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 3'b000) rv++;
        end
        checks++;
        if (rv !== 0) begin
            errors++;
            $display("[TB] FAIL mid_no_rsp: got %0d rsp cycles expected 0", rv);
        end
        model_hang = 1'b0;
        reset = 1'b0;
        req_data[0] = {CODEC_ADDR, 16'h0101};
        req = 3'b101;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("[TB] FAIL mid_ptr_cleared: got gnt=%b expected 001", gnt);
        end
        wait_rsp(200, n);
        checks++;
        if (rsp_valid !== 3'b001 || rsp_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_after_rsp: got rsp=%b ack=%b expected 001/1", rsp_valid, rsp_ack);
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_round_robin();
        test_single();
        test_ptr_order();
        test_nack_retry();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
